// File: rtl/das_sum_if.sv
// Bus bundle between the delay-and-sum engine and its frame controller and RAMs.
// The engine connects through the master modport; the environment drives the slave side.
interface das_sum_if #(
    parameter int NUM_CH     = 8,
    parameter int NUM_PTS    = 768,
    parameter int SAMP_DEPTH = 6144,
    parameter int SAMP_W     = 32,
    parameter int DLY_W      = 13,
    parameter int SUM_W      = SAMP_W + $clog2(NUM_CH) + 1
);
    localparam int DLY_AW = $clog2(NUM_CH * NUM_PTS);
    localparam int SMP_AW = $clog2(NUM_CH * SAMP_DEPTH);
    localparam int PT_W   = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;

    logic              start;
    logic [NUM_CH-1:0] ch_mask;
    logic              busy;
    logic              done;
    logic              dly_rd_en;
    logic [DLY_AW-1:0] dly_rd_addr;
    logic [DLY_W-1:0]  dly_rd_data;
    logic              smp_rd_en;
    logic [SMP_AW-1:0] smp_rd_addr;
    logic [SAMP_W-1:0] smp_rd_data;
    logic              sum_wr_en;
    logic [PT_W-1:0]   sum_wr_addr;
    logic [SUM_W-1:0]  sum_wr_data;
    logic [15:0]       oob_cnt;

    modport master (
        input  start, ch_mask, dly_rd_data, smp_rd_data,
        output busy, done, dly_rd_en, dly_rd_addr, smp_rd_en, smp_rd_addr,
               sum_wr_en, sum_wr_addr, sum_wr_data, oob_cnt
    );

    modport slave (
        output start, ch_mask, dly_rd_data, smp_rd_data,
        input  busy, done, dly_rd_en, dly_rd_addr, smp_rd_en, smp_rd_addr,
               sum_wr_en, sum_wr_addr, sum_wr_data, oob_cnt
    );
endinterface

// File: rtl/das_sum_engine.sv
// Delay-and-sum engine: per output point, reads one delay per enabled channel, fetches the
// delayed sample, accumulates across channels and writes the sum to the sum RAM.
module das_sum_engine #(
    parameter int NUM_CH     = 8,
    parameter int NUM_PTS    = 768,
    parameter int SAMP_DEPTH = 6144,
    parameter int SAMP_W     = 32,
    parameter int DLY_W      = 13,
    parameter int RD_LAT     = 2,
    parameter bit SIGNED     = 1'b1,
    parameter int SUM_W      = SAMP_W + $clog2(NUM_CH) + 1
) (
    input logic       clk,
    input logic       reset_n,
    das_sum_if.master bus
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PT_W   = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;
    localparam int DLY_AW = $clog2(NUM_CH * NUM_PTS);
    localparam int SMP_AW = $clog2(NUM_CH * SAMP_DEPTH);
    localparam int WT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DLY_RD, S_DLY_WT, S_SMP_RD, S_SMP_WT, S_WRITE, S_FIN
    } state_t;

    typedef struct packed {
        logic            found;
        logic [CH_W-1:0] idx;
    } ch_sel_t;

    // Lowest enabled channel at or above 'from'; found=0 when none remain.
    function automatic ch_sel_t find_ch(input logic [NUM_CH-1:0] mask, input int from);
        ch_sel_t sel;
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && i >= from) begin
                sel.found = 1'b1;
                sel.idx   = CH_W'(i);
            end
        end
        return sel;
    endfunction

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PT_W-1:0]   p_q, p_d;
    logic [WT_W-1:0]   wt_q, wt_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [15:0]       oob_q, oob_d;

    ch_sel_t          start_sel, first_sel, next_sel;
    logic             wt_last, p_last, dly_oob, smp_sign;
    logic [SUM_W-1:0] smp_ext;

    assign start_sel = find_ch(bus.ch_mask, 0);
    assign first_sel = find_ch(mask_q, 0);
    assign next_sel  = find_ch(mask_q, int'(ch_q) + 1);
    assign wt_last   = (wt_q == WT_W'(RD_LAT - 1));
    assign p_last    = (p_q == PT_W'(NUM_PTS - 1));
    assign dly_oob   = (32'(bus.dly_rd_data) >= 32'(SAMP_DEPTH));
    assign smp_sign  = SIGNED & bus.smp_rd_data[SAMP_W-1];
    assign smp_ext   = {{(SUM_W - SAMP_W){smp_sign}}, bus.smp_rd_data};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            ch_q    <= '0;
            p_q     <= '0;
            wt_q    <= '0;
            dly_q   <= '0;
            acc_q   <= '0;
            oob_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            p_q     <= p_d;
            wt_q    <= wt_d;
            dly_q   <= dly_d;
            acc_q   <= acc_d;
            oob_q   <= oob_d;
        end
    end

    // NOTE: every variable gets its hold value first, so no branch can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        p_d     = p_q;
        wt_d    = wt_q;
        dly_d   = dly_q;
        acc_d   = acc_q;
        oob_d   = oob_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mask_d  = bus.ch_mask;
                    oob_d   = '0;
                    p_d     = '0;
                    acc_d   = '0;
                    ch_d    = start_sel.idx;
                    state_d = start_sel.found ? S_DLY_RD : S_WRITE;
                end
            end
            S_DLY_RD: begin
                wt_d    = '0;
                state_d = S_DLY_WT;
            end
            S_DLY_WT: begin
                if (!wt_last) begin
                    wt_d = wt_q + WT_W'(1);
                end else if (dly_oob) begin
                    // Out-of-range delay contributes nothing and skips its sample read.
                    oob_d   = (oob_q == 16'hFFFF) ? oob_q : oob_q + 16'd1;
                    ch_d    = next_sel.idx;
                    state_d = next_sel.found ? S_DLY_RD : S_WRITE;
                end else begin
                    dly_d   = bus.dly_rd_data;
                    state_d = S_SMP_RD;
                end
            end
            S_SMP_RD: begin
                wt_d    = '0;
                state_d = S_SMP_WT;
            end
            S_SMP_WT: begin
                if (!wt_last) begin
                    wt_d = wt_q + WT_W'(1);
                end else begin
                    acc_d   = acc_q + smp_ext;
                    ch_d    = next_sel.idx;
                    state_d = next_sel.found ? S_DLY_RD : S_WRITE;
                end
            end
            S_WRITE: begin
                acc_d = '0;
                ch_d  = first_sel.idx;
                if (p_last) begin
                    state_d = S_FIN;
                end else begin
                    p_d     = p_q + PT_W'(1);
                    state_d = first_sel.found ? S_DLY_RD : S_WRITE;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state_q != S_IDLE) && (state_q != S_FIN);
        bus.done        = (state_q == S_FIN);
        bus.oob_cnt     = oob_q;
        bus.dly_rd_en   = 1'b0;
        bus.dly_rd_addr = '0;
        bus.smp_rd_en   = 1'b0;
        bus.smp_rd_addr = '0;
        bus.sum_wr_en   = 1'b0;
        bus.sum_wr_addr = '0;
        bus.sum_wr_data = '0;

        case (state_q)
            S_DLY_RD: begin
                bus.dly_rd_en   = 1'b1;
                bus.dly_rd_addr = DLY_AW'(32'(ch_q) * 32'(NUM_PTS) + 32'(p_q));
            end
            S_SMP_RD: begin
                bus.smp_rd_en   = 1'b1;
                bus.smp_rd_addr = SMP_AW'(32'(ch_q) * 32'(SAMP_DEPTH) + 32'(dly_q));
            end
            S_WRITE: begin
                bus.sum_wr_en   = 1'b1;
                bus.sum_wr_addr = p_q;
                bus.sum_wr_data = acc_q;
            end
            default: ;
        endcase
    end
endmodule
